// File: rtl/game_flow_sequencer_if.sv
// ============================================================================
// Module      : game_flow_sequencer_if
// Description : Bundle between the game-flow sequencer and the road/VGA side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_flow_sequencer_if;
    logic        start;
    logic        crash;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        play_en;
    logic        road_reset;
    logic [3:0]  level;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [2:0]  state;

    modport master (
        output start, crash, hCount, vCount,
        input  play_en, road_reset, level, score, lives, state
    );

    modport slave (
        input  start, crash, hCount, vCount,
        output play_en, road_reset, level, score, lives, state
    );
endinterface

`default_nettype wire

// File: rtl/game_flow_sequencer.sv
// ============================================================================
// Module      : game_flow_sequencer
// Description : Road-game flow controller (idle/countdown/play/crash/over).
//               Optional PAUSE state enabled by defining GAME_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_flow_sequencer #(
    parameter int LIVES_INIT       = 3,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int CRASH_FRAMES     = 90,
    parameter int LEVEL_FRAMES     = 600,
    parameter int LEVEL_MAX        = 8,
    parameter int V_TICK_LINE      = 480
) (
    input  wire logic             clk,
    input  wire logic             rst,
    game_flow_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_CRASH     = 3'd3,
        S_OVER      = 3'd4,
        S_PAUSE     = 3'd5
    } state_t;

    state_t      state_q,      state_d;
    logic        start_q;
    logic        tick_cond_q;
    logic        tick_q;
    logic        road_reset_q, road_reset_d;
    logic [7:0]  timer_q,      timer_d;
    logic [9:0]  level_cnt_q,  level_cnt_d;
    logic [3:0]  level_q,      level_d;
    logic [15:0] score_q,      score_d;
    logic [1:0]  lives_q,      lives_d;

    logic        start_rise;
    logic        tick_cond;

    assign start_rise = bus.start & ~start_q;
    assign tick_cond  = (bus.hCount == 10'd0) && (bus.vCount == 10'(V_TICK_LINE));

    // start_q resets high so a button held through reset release is not a new press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b1;
            tick_cond_q  <= 1'b0;
            tick_q       <= 1'b0;
            road_reset_q <= 1'b0;
            timer_q      <= 8'd0;
            level_cnt_q  <= 10'd0;
            level_q      <= 4'd1;
            score_q      <= 16'd0;
            lives_q      <= 2'(LIVES_INIT);
        end else begin
            state_q      <= state_d;
            start_q      <= bus.start;
            tick_cond_q  <= tick_cond;
            tick_q       <= tick_cond & ~tick_cond_q;
            road_reset_q <= road_reset_d;
            timer_q      <= timer_d;
            level_cnt_q  <= level_cnt_d;
            level_q      <= level_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        road_reset_d = 1'b0;
        timer_d      = timer_q;
        level_cnt_d  = level_cnt_q;
        level_d      = level_q;
        score_d      = score_q;
        lives_d      = lives_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d      = S_COUNTDOWN;
                    road_reset_d = 1'b1;
                    lives_d      = 2'(LIVES_INIT);
                    level_d      = 4'd1;
                    score_d      = 16'd0;
                    level_cnt_d  = 10'd0;
                    timer_d      = 8'(COUNTDOWN_FRAMES);
                end
            end

            S_COUNTDOWN: begin
                if (tick_q) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        state_d = S_PLAY;
                    end
                end
            end

            S_PLAY: begin
                // A crash wins over a coincident tick; that frame is not scored
                if (bus.crash) begin
                    state_d     = S_CRASH;
                    timer_d     = 8'(CRASH_FRAMES);
                    level_cnt_d = 10'd0;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
`ifdef GAME_PAUSE_EN
                end else if (start_rise) begin
                    state_d = S_PAUSE;
`endif
                end else if (tick_q) begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    if (level_cnt_q + 10'd1 == 10'(LEVEL_FRAMES)) begin
                        level_cnt_d = 10'd0;
                        if (level_q < 4'(LEVEL_MAX)) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        level_cnt_d = level_cnt_q + 10'd1;
                    end
                end
            end

            S_CRASH: begin
                if (tick_q) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        if (lives_q == 2'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d      = S_COUNTDOWN;
                            road_reset_d = 1'b1;
                            timer_d      = 8'(COUNTDOWN_FRAMES);
                        end
                    end
                end
            end

`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (start_rise) begin
                    state_d = S_PLAY;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.play_en    = (state_q == S_PLAY);
    assign bus.road_reset = road_reset_q;
    assign bus.level      = level_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.state      = state_q;

endmodule

`default_nettype wire
